// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-controller bus seen by mem_port_arbiter.
// master is the arbiter's view; slave is the CPU/memory environment's view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_adr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_cs;
    logic        mem_wren;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        mem_error;

    modport master (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_rdy, mem_error,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_cs, mem_wren, mem_adr, mem_wdata
    );
    modport slave (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_rdy, mem_error,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_cs, mem_wren, mem_adr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU fetch and data ports onto one memory bus, with misalignment
// and timeout detection. One transfer in flight: IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int DATA_STREAK_MAX = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(DATA_STREAK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic          cs, cs_n, wren, wren_n, gnt_d, gnt_d_n, err, err_n;
    logic [31:0]   adr, adr_n, wdata, wdata_n, rdata, rdata_n;
    logic [SW-1:0] streak, streak_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          pick_i, ack_i, ack_d;
    logic [31:0]   sel_adr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cs     <= 1'b0;
            wren   <= 1'b0;
            gnt_d  <= 1'b0;
            err    <= 1'b0;
            adr    <= '0;
            wdata  <= '0;
            rdata  <= '0;
            streak <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            cs     <= cs_n;
            wren   <= wren_n;
            gnt_d  <= gnt_d_n;
            err    <= err_n;
            adr    <= adr_n;
            wdata  <= wdata_n;
            rdata  <= rdata_n;
            streak <= streak_n;
            tcnt   <= tcnt_n;
        end
    end

    // Fetch wins only when data has had its full streak, or data is not asking.
    assign pick_i  = bus.i_req && (!bus.d_req || streak == SW'(DATA_STREAK_MAX));
    assign sel_adr = pick_i ? bus.i_adr : bus.d_adr;

    always_comb begin
        state_n  = state;
        cs_n     = cs;
        wren_n   = wren;
        gnt_d_n  = gnt_d;
        err_n    = err;
        adr_n    = adr;
        wdata_n  = wdata;
        rdata_n  = rdata;
        streak_n = streak;
        tcnt_n   = '0;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    gnt_d_n  = !pick_i;
                    adr_n    = sel_adr;
                    wdata_n  = pick_i ? 32'h0 : bus.d_wdata;
                    err_n    = 1'b0;
                    rdata_n  = '0;
                    if (pick_i)
                        streak_n = '0;
                    else if (streak != SW'(DATA_STREAK_MAX))
                        streak_n = streak + SW'(1);
                    if (sel_adr[1:0] != 2'b00) begin
                        // Misaligned: complete with error without touching the bus.
                        err_n   = 1'b1;
                        wren_n  = 1'b0;
                        state_n = DONE;
                    end else begin
                        cs_n    = 1'b1;
                        wren_n  = !pick_i && bus.d_we;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_error) begin
                    cs_n    = 1'b0;
                    wren_n  = 1'b0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                tcnt_n = tcnt + TW'(1);
                if (bus.mem_rdy) begin
                    cs_n    = 1'b0;
                    wren_n  = 1'b0;
                    tcnt_n  = '0;
                    state_n = DONE;
                    if (bus.mem_error)
                        err_n = 1'b1;
                    else if (!wren)
                        rdata_n = bus.mem_rdata;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    cs_n    = 1'b0;
                    wren_n  = 1'b0;
                    err_n   = 1'b1;
                    tcnt_n  = '0;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign ack_i = (state == DONE) && !gnt_d;
    assign ack_d = (state == DONE) && gnt_d;

    assign bus.i_ack     = ack_i;
    assign bus.i_err     = ack_i && err;
    assign bus.i_rdata   = ack_i ? rdata : 32'h0;
    assign bus.d_ack     = ack_d;
    assign bus.d_err     = ack_d && err;
    assign bus.d_rdata   = ack_d ? rdata : 32'h0;
    assign bus.mem_cs    = cs;
    assign bus.mem_wren  = wren;
    assign bus.mem_adr   = adr;
    assign bus.mem_wdata = wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter plus hand sequences for
// reset-in-flight and fetch/data streak fairness.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .DATA_STREAK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // chk bit0: compare mem_adr, bit1: compare mem_wdata
    typedef struct {
        logic [31:0] ireq, iadr, dreq, dwe, dadr, dwdata, mrdata, mrdy, merr;
        logic [31:0] iack, ierr, irdata, dack, derr, drdata, cs, wren, chk, adr, wdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_req     = v.ireq[0];
        bus.i_adr     = v.iadr;
        bus.d_req     = v.dreq[0];
        bus.d_we      = v.dwe[0];
        bus.d_adr     = v.dadr;
        bus.d_wdata   = v.dwdata;
        bus.mem_rdata = v.mrdata;
        bus.mem_rdy   = v.mrdy[0];
        bus.mem_error = v.merr[0];
    endtask

    task automatic apply(input vec_t v, input int r);
        drive(v);
        @(posedge clk);
        #1;
        chk("i_ack",    r, 32'(bus.i_ack),    v.iack);
        chk("i_err",    r, 32'(bus.i_err),    v.ierr);
        chk("i_rdata",  r, bus.i_rdata,       v.irdata);
        chk("d_ack",    r, 32'(bus.d_ack),    v.dack);
        chk("d_err",    r, 32'(bus.d_err),    v.derr);
        chk("d_rdata",  r, bus.d_rdata,       v.drdata);
        chk("mem_cs",   r, 32'(bus.mem_cs),   v.cs);
        chk("mem_wren", r, 32'(bus.mem_wren), v.wren);
        if (v.chk[0]) chk("mem_adr",   r, bus.mem_adr,   v.adr);
        if (v.chk[1]) chk("mem_wdata", r, bus.mem_wdata, v.wdata);
    endtask

    initial begin
        vec_t  z;
        int    n;
        string exp_seq;

        // Each row: inputs during a cycle, outputs expected after the following edge.
        // Fetch 0x100, mem_rdy in 2nd WAIT cycle.
        tbl.push_back('{1,'h100,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h100,0});
        tbl.push_back('{1,'h100,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h100,0});
        tbl.push_back('{1,'h100,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h100,0});
        tbl.push_back('{1,'h100,0,0,0,0, 'hDEADBEEF,1,0, 1,0,'hDEADBEEF,0,0,0, 0,0, 0,0,0});
        tbl.push_back('{1,'h100,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        // Data write 0x40; mem_rdy during ISSUE must be ignored.
        tbl.push_back('{0,0,1,1,'h40,'h12345678, 0,0,0, 0,0,0,0,0,0, 1,1, 3,'h40,'h12345678});
        tbl.push_back('{0,0,1,1,'h40,'h12345678, 'hFFFFFFFF,1,0, 0,0,0,0,0,0, 1,1, 3,'h40,'h12345678});
        tbl.push_back('{0,0,1,1,'h40,'h12345678, 0,0,0, 0,0,0,0,0,0, 1,1, 3,'h40,'h12345678});
        tbl.push_back('{0,0,1,1,'h40,'h12345678, 'hFFFFFFFF,1,0, 0,0,0,1,0,0, 0,0, 2,0,'h12345678});
        tbl.push_back('{0,0,1,1,'h40,'h12345678, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        // Misaligned data read: straight to DONE, no chip select.
        tbl.push_back('{0,0,1,0,'h41,0, 0,0,0, 0,0,0,1,1,0, 0,0, 0,0,0});
        tbl.push_back('{0,0,1,0,'h41,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        // mem_error in ISSUE.
        tbl.push_back('{0,0,1,0,'h40000000,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h40000000,0});
        tbl.push_back('{0,0,1,0,'h40000000,0, 'h11111111,0,1, 0,0,0,1,1,0, 0,0, 0,0,0});
        tbl.push_back('{0,0,1,0,'h40000000,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        // Timeout with TIMEOUT_CYCLES=8: eight WAIT cycles then error ack.
        tbl.push_back('{0,0,1,1,'h80,'hA5A55A5A, 0,0,0, 0,0,0,0,0,0, 1,1, 3,'h80,'hA5A55A5A});
        for (int k = 0; k < 8; k++)
            tbl.push_back('{0,0,1,1,'h80,'hA5A55A5A, 0,0,0, 0,0,0,0,0,0, 1,1, 3,'h80,'hA5A55A5A});
        tbl.push_back('{0,0,1,1,'h80,'hA5A55A5A, 0,0,0, 0,0,0,1,1,0, 0,0, 0,0,0});
        tbl.push_back('{0,0,1,1,'h80,'hA5A55A5A, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        // Fetch with mem_rdy and mem_error together: error wins, rdata 0.
        tbl.push_back('{1,'h200,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h200,0});
        tbl.push_back('{1,'h200,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0, 1,'h200,0});
        tbl.push_back('{1,'h200,0,0,0,0, 'h1234,1,1, 1,1,0,0,0,0, 0,0, 0,0,0});
        tbl.push_back('{1,'h200,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});
        tbl.push_back('{0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0});

        z = '{0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0};
        drive(z);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs",    0, 32'(bus.mem_cs),  0);
        chk("rst_i_ack", 0, 32'(bus.i_ack),   0);
        chk("rst_d_ack", 0, 32'(bus.d_ack),   0);
        chk("rst_adr",   0, bus.mem_adr,      0);
        rst = 1'b1;

        foreach (tbl[r]) apply(tbl[r], r);

        // Reset asserted mid-WAIT drops the transfer; held request is re-serviced.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 32'h300; bus.d_wdata = 32'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cs", 100, 32'(bus.mem_cs), 1);
        rst = 1'b0;
        #1;
        chk("rst_cs",    101, 32'(bus.mem_cs),   0);
        chk("rst_wren",  101, 32'(bus.mem_wren), 0);
        chk("rst_adr",   101, bus.mem_adr,       0);
        chk("rst_wdata", 101, bus.mem_wdata,     0);
        bus.mem_rdy = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_noack", 102, 32'(bus.d_ack | bus.i_ack), 0);
        end
        bus.mem_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("resvc_cs",   103, 32'(bus.mem_cs),   1);
        chk("resvc_wren", 103, 32'(bus.mem_wren), 1);
        chk("resvc_adr",  103, bus.mem_adr,       32'h300);
        @(posedge clk); #1;
        bus.mem_rdy = 1'b1;
        @(posedge clk); #1;
        chk("resvc_ack", 104, 32'(bus.d_ack), 1);
        chk("resvc_err", 104, 32'(bus.d_err), 0);
        bus.d_req = 1'b0; bus.mem_rdy = 1'b0;
        @(posedge clk); #1;

        // Both ports held: four data grants then one fetch, 4 cycles per transfer.
        rst = 1'b0; #2; rst = 1'b1;
        exp_seq = "DDDDIDDDDI";
        bus.i_req = 1'b1; bus.i_adr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 32'h20;
        bus.mem_rdy = 1'b1; bus.mem_rdata = 32'h77;
        n = 0;
        for (int cyc = 1; cyc <= 60 && n < 10; cyc++) begin
            @(posedge clk); #1;
            chk("one_ack", cyc, 32'(bus.i_ack & bus.d_ack), 0);
            if (bus.i_ack || bus.d_ack) begin
                chk("grant", n, bus.d_ack ? 32'("D") : 32'("I"), 32'(exp_seq[n]));
                chk("ack_cycle", n, cyc, 3 + 4 * n);
                n++;
            end
        end
        chk("grant_count", 0, n, 10);
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_rdy = 1'b0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
